// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter feeding a single registered adder.
// One operation in flight: IDLE grants, EXEC adds, RESP holds the result.
module adder_rr_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  resp_valid,
    output logic [WIDTH-1:0]      resp_data,
    output logic [2:0]            resp_id,
    input  logic                  resp_ready,
    output logic [15:0]           ops_count
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [2:0]       ptr;
    logic [2:0]       grant_id;
    logic             grant_any;
    logic [3:0]       idx;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [2:0]       op_id;

    // First valid requester at or after ptr, wrapping at NREQ.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= 4'(NREQ)) begin
                idx = idx - 4'(NREQ);
            end
            for (int j = 0; j < NREQ; j++) begin
                if (!grant_any && idx == 4'(j) && req_valid[j]) begin
                    grant_any = 1'b1;
                    grant_id  = 3'(j);
                end
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == 3'(i)) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (grant_any) state_next = EXEC;
            EXEC: state_next = RESP;
            RESP: if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        resp_valid = (state == RESP);
        if (state == IDLE && grant_any && !reset) begin
            req_ready = {{(NREQ-1){1'b0}}, 1'b1} << grant_id;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
            resp_data <= '0;
            resp_id   <= '0;
            ops_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_any) begin
                        op_a  <= sel_a;
                        op_b  <= sel_b;
                        op_id <= grant_id;
                    end
                end
                EXEC: begin
                    resp_data <= op_a + op_b;
                    resp_id   <= op_id;
                end
                RESP: begin
                    if (resp_ready) begin
                        ptr       <= (op_id == 3'(NREQ-1)) ? 3'd0 : op_id + 3'd1;
                        ops_count <= ops_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed bench for adder_rr_arbiter: latency, overflow, backpressure,
// reset in flight, round-robin order and pointer wrap.
module tb_adder_rr_arbiter;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic           resp_valid;
    logic [W-1:0]   resp_data;
    logic [2:0]     resp_id;
    logic           resp_ready;
    logic [15:0]    ops_count;

    int checks = 0;
    int errors = 0;

    adder_rr_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_ready (resp_ready),
        .ops_count  (ops_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a,
                          input logic [31:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_data", resp_data, 32'd0);
        chk("rst_id", 32'(resp_id), 32'd0);
        chk("rst_count", 32'(ops_count), 32'd0);
        req_valid = 4'b1111;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);

        // single op, grant at T
        reset     = 1'b0;
        req_valid = 4'b0001;
        set_op(0, 32'd5, 32'hFFFF_FFF9);
        #1;
        chk("single_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        set_op(0, 32'd100, 32'd100);
        #1;
        chk("single_t1_valid", 32'(resp_valid), 32'd0);
        chk("single_t1_ready", 32'(req_ready), 32'd0);
        tick();
        chk("single_t2_valid", 32'(resp_valid), 32'd1);
        chk("single_data", resp_data, 32'hFFFF_FFFE);
        chk("single_id", 32'(resp_id), 32'd0);
        resp_ready = 1'b1;
        tick();
        chk("single_done", 32'(resp_valid), 32'd0);
        chk("single_count", 32'(ops_count), 32'd1);
        resp_ready = 1'b0;

        // overflow on requester 1 (ptr is now 1), then backpressure
        req_valid = 4'b0010;
        set_op(1, 32'h7FFF_FFFF, 32'd1);
        #1;
        chk("ovf_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b1111;
        tick();
        for (int c = 1; c <= 5; c++) begin
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_data", resp_data, 32'h8000_0000);
            chk("bp_id", 32'(resp_id), 32'd1);
            chk("bp_ready", 32'(req_ready), 32'd0);
            tick();
        end
        req_valid  = 4'b0000;
        resp_ready = 1'b1;
        #1;
        chk("bp_c6_valid", 32'(resp_valid), 32'd1);
        tick();
        chk("bp_idle", 32'(resp_valid), 32'd0);
        chk("bp_count", 32'(ops_count), 32'd2);
        resp_ready = 1'b0;

        // reset while in EXEC
        req_valid = 4'b0100;
        set_op(2, 32'd9, 32'd9);
        #1;
        chk("rx_grant", 32'(req_ready), 32'h4);
        tick();
        reset     = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("rx_ready", 32'(req_ready), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("rx_valid", 32'(resp_valid), 32'd0);
        chk("rx_count", 32'(ops_count), 32'd0);
        chk("rx_data", resp_data, 32'd0);
        chk("rx_ptr", 32'(req_ready), 32'h1);

        // all four requesting, consumer always ready
        for (int i = 0; i < N; i++) begin
            set_op(i, 32'h1000_0000 * i + 32'd3, 32'd7 * i);
        end
        resp_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            chk("rr_grant", 32'(req_ready), 32'(1 << (g % N)));
            tick();
            chk("rr_exec", 32'(resp_valid), 32'd0);
            tick();
            chk("rr_valid", 32'(resp_valid), 32'd1);
            chk("rr_id", 32'(resp_id), 32'(g % N));
            chk("rr_data", resp_data,
                32'h1000_0000 * (g % N) + 32'd3 + 32'd7 * (g % N));
            tick();
        end
        chk("rr_count", 32'(ops_count), 32'd5);

        // drive ptr to 3, then wrap with 1001
        req_valid = 4'b0100;
        #1;
        chk("wrap_pre", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b0000;
        tick();
        tick();
        req_valid = 4'b1001;
        #1;
        chk("wrap_g3", 32'(req_ready), 32'h8);
        tick();
        tick();
        chk("wrap_id3", 32'(resp_id), 32'd3);
        tick();
        chk("wrap_g0", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        tick();
        chk("wrap_id0", 32'(resp_id), 32'd0);
        tick();
        chk("final_count", 32'(ops_count), 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_rr_arbiter.md
ADDER_RR_ARBITER -- requirements
Module: adder_rr_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand and result width (signed, two's complement).
REQ-002 Parameter NREQ, default 4, SHALL set the requester count; the legal range SHALL be 2..8.
REQ-003 Clock and reset SHALL be as follows: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  SHALL be the only clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be the synchronous active-high reset.
REQ-006 req_valid  input  NREQ  SHALL carry the per-requester "operands present" flags.
REQ-007 req_a  input  NREQ*WIDTH  SHALL carry the packed operand A per requester; requester i occupies slice [i*WIDTH +: WIDTH].
REQ-008 req_b  input  NREQ*WIDTH  SHALL carry the packed operand B per requester, packed the same way as req_a.
REQ-009 req_ready  output  NREQ  SHALL be the one-hot grant/accept, combinational from state and req_valid.
REQ-010 resp_valid  output  1  SHALL flag that the result is valid.
REQ-011 resp_data  output  WIDTH  SHALL carry the registered sum.
REQ-012 resp_id  output  3  SHALL carry the index of the requester that owns resp_data.
REQ-013 resp_ready  input  1  SHALL be the consumer accept signal.
REQ-014 ops_count  output  16  SHALL count completed operations.

Function
REQ-015 The FSM SHALL have exactly 3 states: IDLE, EXEC and RESP.
REQ-016 In IDLE, with any req_valid set, the block SHALL assert req_ready for exactly one requester, picked round-robin from ptr upward with wrap-around; the transfer occurs that cycle.
REQ-017 On transfer, the block SHALL capture the granted req_a/req_b/index into operand registers and go to EXEC.
REQ-018 In IDLE with no req_valid set, the block SHALL stay in IDLE with req_ready all zero.
REQ-019 req_ready SHALL be all zero in EXEC and RESP.
REQ-020 EXEC SHALL last 1 cycle: resp_data <= opA + opB, truncated to WIDTH bits (overflow wraps, no saturation, no flag); then go to RESP.
REQ-021 In RESP, resp_valid SHALL be 1 and resp_data/resp_id SHALL be held stable until resp_ready = 1.
REQ-022 In RESP with resp_ready = 1, the block SHALL go to IDLE, set ptr to (granted index + 1) mod NREQ, and increment ops_count (wrapping 0xFFFF -> 0).
REQ-023 Latency: a grant at cycle T SHALL produce resp_valid at T+2; best-case throughput SHALL be 1 operation per 3 cycles.
REQ-024 A requester dropping req_valid while not granted SHALL lose nothing and SHALL never be granted in that state.
REQ-025 Operand changes after capture SHALL NOT affect the in-flight result.
REQ-026 resp_ready asserted outside RESP SHALL be ignored.
REQ-027 Fairness: a continuously requesting requester SHALL be granted within NREQ grants.

Reset
REQ-028 Reset SHALL take priority over all other events, including a grant or response handshake in the same cycle.
REQ-029 Reset SHALL force the state to IDLE, ptr = 0, resp_valid = 0, resp_data = 0, resp_id = 0 and ops_count = 0.
REQ-030 Reset mid-operation (EXEC or RESP) SHALL discard the operation without counting it; req_ready SHALL be all zero during the reset cycle.

Verification
REQ-031 Single op: req_valid = 0001, a = 5, b = -7; grant at T -> resp_valid at T+2, resp_data = -2, resp_id = 0, ops_count = 1 after resp_ready.
REQ-032 Overflow: a = 0x7FFFFFFF, b = 1 -> resp_data = 0x80000000.
REQ-033 All four requesting continuously with resp_ready = 1 -> grant order 0, 1, 2, 3, 0; each response 3 cycles apart.
REQ-034 Backpressure: resp_ready held 0 for 5 cycles in RESP -> resp_valid, resp_data and resp_id stable, no new grant; accept on cycle 6 -> IDLE next cycle.
REQ-035 Reset asserted while in EXEC -> next cycle IDLE, resp_valid = 0, ops_count unchanged at its reset value 0, ptr = 0.
REQ-036 Pointer wrap: ptr = 3 with req_valid = 1001 -> grant requester 3, then requester 0.
